// File: rtl/iiitb_rc_pkg.sv
// Shared constants and seed helper for the parameterised ring/Johnson counter.
// Both count modes, both shift directions and the per-mode seed value are defined here.
package iiitb_rc_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_LEFT     = 1'b0;
  localparam logic DIR_RIGHT    = 1'b1;

  localparam int MAX_WIDTH = 32;

  // Callers truncate the result to their own width.
  // Ring mode seeds at one-hot bit 0; Johnson mode seeds at all-zeros.
  function automatic logic [MAX_WIDTH-1:0] seed_of(input logic mode);
    return (mode == MODE_RING) ? 32'd1 : 32'd0;
  endfunction

endpackage

// File: rtl/iiitb_rc_legal_chk.sv
// Combinational legality check for a candidate counter value in the selected mode.
// Ring values must be one-hot. Johnson values may have at most one adjacent bit pair that differs.
module iiitb_rc_legal_chk
  import iiitb_rc_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] value,
  output logic             legal
);

  int ones;
  int edges;

  always_comb begin
    ones  = $countones(value);
    edges = 0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      edges = edges + int'(value[i] ^ value[i+1]);
    end
    if (mode == MODE_RING) begin
      legal = (ones == 1);
    end else begin
      legal = (edges <= 1);
    end
  end

endmodule

// File: rtl/iiitb_param_rc.sv
// Parameterised ring / Johnson counter with direction control and checked parallel load.
// Wrap pulses when an Enable step lands on the seed; Err pulses when an illegal load is replaced by the seed.
module iiitb_param_rc
  import iiitb_rc_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Enable,
  input  logic             Mode,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] Load_val,
  output logic [WIDTH-1:0] Count_out,
  output logic             Wrap,
  output logic             Err
);

  logic             mode_q;
  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic             err_q;

  logic [WIDTH-1:0] count_d;
  logic             wrap_d;
  logic             err_d;

  logic [WIDTH-1:0] seed_cur;
  logic [WIDTH-1:0] seed_new;
  logic [WIDTH-1:0] step_val;
  logic             load_legal;

  assign seed_cur = WIDTH'(seed_of(mode_q));
  assign seed_new = WIDTH'(seed_of(Mode));

  iiitb_rc_legal_chk #(.WIDTH(WIDTH)) u_legal (
    .mode  (mode_q),
    .value (Load_val),
    .legal (load_legal)
  );

  // Johnson differs from ring only by inverting the bit that wraps around.
  always_comb begin
    step_val = count_q;
    if (Dir == DIR_LEFT) begin
      step_val = {count_q[WIDTH-2:0],
                  (mode_q == MODE_JOHNSON) ? ~count_q[WIDTH-1] : count_q[WIDTH-1]};
    end else begin
      step_val = {(mode_q == MODE_JOHNSON) ? ~count_q[0] : count_q[0],
                  count_q[WIDTH-1:1]};
    end
  end

  // Priority: Mode change, then Load, then Enable, otherwise hold.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (Mode != mode_q) begin
      count_d = seed_new;
    end else if (Load) begin
      if (load_legal) begin
        count_d = Load_val;
      end else begin
        count_d = seed_cur;
        err_d   = 1'b1;
      end
    end else if (Enable) begin
      count_d = step_val;
      wrap_d  = (step_val == seed_cur);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      mode_q  <= Mode;
      count_q <= seed_new;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      mode_q  <= Mode;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign Count_out = count_q;
  assign Wrap      = wrap_q;
  assign Err       = err_q;

endmodule

// File: tb/tb_iiitb_param_rc.sv
// Bench for iiitb_param_rc: WIDTH=3 and WIDTH=8 instances share control inputs.
// Directed vector table, period sequences and random traffic against a sequence-index model.
module tb_iiitb_param_rc;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Enable = 1'b0;
  logic       Mode = 1'b0;
  logic       Dir = 1'b0;
  logic       Load = 1'b0;
  logic [2:0] load_val3 = '0;
  logic [7:0] load_val8 = '0;
  logic [2:0] count3;
  logic [7:0] count8;
  logic       wrap3, err3, wrap8, err8;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  iiitb_param_rc #(.WIDTH(3)) u_dut3 (
    .Clock(Clock), .Reset_n(Reset_n), .Enable(Enable), .Mode(Mode), .Dir(Dir),
    .Load(Load), .Load_val(load_val3), .Count_out(count3), .Wrap(wrap3), .Err(err3)
  );

  iiitb_param_rc #(.WIDTH(8)) u_dut8 (
    .Clock(Clock), .Reset_n(Reset_n), .Enable(Enable), .Mode(Mode), .Dir(Dir),
    .Load(Load), .Load_val(load_val8), .Count_out(count8), .Wrap(wrap8), .Err(err8)
  );

  // Reference model: the counter is a position index in the mode's cycle.
  // Index 0 is the seed. Moving left adds one to the index; moving right subtracts one.
  logic m_mode[2];
  int   m_idx[2];
  logic m_wrap[2];
  logic m_err[2];
  int   m_w[2];

  function automatic int period(input logic mode, input int w);
    return mode ? 2 * w : w;
  endfunction

  function automatic logic [31:0] val_of(input logic mode, input int idx, input int w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    if (!mode) return 32'd1 << idx;
    if (idx <= w) return (32'd1 << idx) - 32'd1;
    return mask & ~((32'd1 << (idx - w)) - 32'd1);
  endfunction

  function automatic int idx_of(input logic mode, input logic [31:0] v, input int w);
    for (int k = 0; k < period(mode, w); k++) begin
      if (val_of(mode, k, w) == v) return k;
    end
    return -1;
  endfunction

  task automatic model_update(input int u, input logic rst_n, input logic mode, input logic dir,
                              input logic en, input logic load, input logic [31:0] lval);
    int k;
    int p;
    m_wrap[u] = 1'b0;
    m_err[u]  = 1'b0;
    if (!rst_n) begin
      m_mode[u] = mode;
      m_idx[u]  = 0;
    end else if (mode != m_mode[u]) begin
      m_mode[u] = mode;
      m_idx[u]  = 0;
    end else if (load) begin
      k = idx_of(m_mode[u], lval, m_w[u]);
      if (k < 0) begin
        m_idx[u] = 0;
        m_err[u] = 1'b1;
      end else begin
        m_idx[u] = k;
      end
    end else if (en) begin
      p = period(m_mode[u], m_w[u]);
      m_idx[u]  = dir ? (m_idx[u] + p - 1) % p : (m_idx[u] + 1) % p;
      m_wrap[u] = (m_idx[u] == 0);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one clock's worth of inputs, advance both models, then compare both instances.
  task automatic cycle(input logic rst_n, input logic mode, input logic dir, input logic en,
                       input logic load, input logic [2:0] lv3, input logic [7:0] lv8);
    Reset_n   = rst_n;
    Mode      = mode;
    Dir       = dir;
    Enable    = en;
    Load      = load;
    load_val3 = lv3;
    load_val8 = lv8;
    @(posedge Clock);
    model_update(0, rst_n, mode, dir, en, load, {29'd0, lv3});
    model_update(1, rst_n, mode, dir, en, load, {24'd0, lv8});
    #1;
    check("model count3", {29'd0, count3}, val_of(m_mode[0], m_idx[0], 3));
    check("model wrap3", {31'd0, wrap3}, {31'd0, m_wrap[0]});
    check("model err3", {31'd0, err3}, {31'd0, m_err[0]});
    check("model count8", {24'd0, count8}, val_of(m_mode[1], m_idx[1], 8));
    check("model wrap8", {31'd0, wrap8}, {31'd0, m_wrap[1]});
    check("model err8", {31'd0, err8}, {31'd0, m_err[1]});
  endtask

  typedef struct {
    logic       rst_n;
    logic       mode;
    logic       dir;
    logic       en;
    logic       load;
    logic [2:0] lval;
    logic [2:0] exp_count;
    logic       exp_wrap;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic m, input logic d, input logic e,
                              input logic l, input logic [2:0] lv, input logic [2:0] c,
                              input logic w, input logic er);
    vec_t v;
    v.rst_n = r; v.mode = m; v.dir = d; v.en = e; v.load = l; v.lval = lv;
    v.exp_count = c; v.exp_wrap = w; v.exp_err = er;
    vecs.push_back(v);
  endfunction

  initial begin
    logic cur_mode;
    logic [31:0] lv;
    m_w[0] = 3; m_w[1] = 8;
    for (int u = 0; u < 2; u++) begin
      m_mode[u] = 1'b0; m_idx[u] = 0; m_wrap[u] = 1'b0; m_err[u] = 1'b0;
    end

    // Ring left, then wrap back to the seed.
    add(0,0,0,1,0,3'b000, 3'b001,0,0);
    add(1,0,0,1,0,3'b000, 3'b010,0,0);
    add(1,0,0,1,0,3'b000, 3'b100,0,0);
    add(1,0,0,1,0,3'b000, 3'b001,1,0);
    // Switch to Johnson, then go once around the cycle in each direction.
    add(1,1,0,1,0,3'b000, 3'b000,0,0);
    add(1,1,0,1,0,3'b000, 3'b001,0,0);
    add(1,1,0,1,0,3'b000, 3'b011,0,0);
    add(1,1,0,1,0,3'b000, 3'b111,0,0);
    add(1,1,0,1,0,3'b000, 3'b110,0,0);
    add(1,1,0,1,0,3'b000, 3'b100,0,0);
    add(1,1,0,1,0,3'b000, 3'b000,1,0);
    add(1,1,1,1,0,3'b000, 3'b100,0,0);
    add(1,1,1,1,0,3'b000, 3'b110,0,0);
    add(1,1,1,1,0,3'b000, 3'b111,0,0);
    add(1,1,1,1,0,3'b000, 3'b011,0,0);
    add(1,1,1,1,0,3'b000, 3'b001,0,0);
    add(1,1,1,1,0,3'b000, 3'b000,1,0);
    // Ring loads: an illegal value falls back to the seed; load wins over enable.
    add(1,0,0,0,0,3'b000, 3'b001,0,0);
    add(1,0,0,0,1,3'b011, 3'b001,0,1);
    add(1,0,0,0,1,3'b100, 3'b100,0,0);
    add(1,0,0,1,1,3'b010, 3'b010,0,0);
    add(1,0,0,0,0,3'b000, 3'b010,0,0);
    // Johnson loads.
    add(1,1,0,0,0,3'b000, 3'b000,0,0);
    add(1,1,0,0,1,3'b101, 3'b000,0,1);
    add(1,1,0,0,1,3'b110, 3'b110,0,0);
    // A Mode toggle while enabled reseeds without stepping.
    add(1,0,0,1,0,3'b000, 3'b001,0,0);
    add(1,0,0,1,0,3'b000, 3'b010,0,0);
    add(1,1,0,1,0,3'b000, 3'b000,0,0);
    add(1,1,0,1,0,3'b000, 3'b001,0,0);
    // Reset overrides a pending load; the first step after reset leaves the seed.
    add(1,0,0,1,0,3'b000, 3'b001,0,0);
    add(1,0,0,1,0,3'b000, 3'b010,0,0);
    add(1,0,0,1,0,3'b000, 3'b100,0,0);
    add(0,0,0,1,1,3'b011, 3'b001,0,0);
    add(1,0,0,1,0,3'b000, 3'b010,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst_n, vecs[i].mode, vecs[i].dir, vecs[i].en, vecs[i].load,
            vecs[i].lval, {5'd0, vecs[i].lval});
      check($sformatf("vec%0d count", i), {29'd0, count3}, {29'd0, vecs[i].exp_count});
      check($sformatf("vec%0d wrap", i), {31'd0, wrap3}, {31'd0, vecs[i].exp_wrap});
      check($sformatf("vec%0d err", i), {31'd0, err3}, {31'd0, vecs[i].exp_err});
    end

    // WIDTH=8 periods: ring wraps after 8 steps, Johnson after 16 in either direction.
    cycle(0, 0, 0, 0, 0, 3'd0, 8'd0);
    check("ring8 seed", {24'd0, count8}, 32'h01);
    for (int i = 1; i <= 8; i++) begin
      cycle(1, 0, 0, 1, 0, 3'd0, 8'd0);
      check($sformatf("ring8 wrap step%0d", i), {31'd0, wrap8}, (i == 8) ? 32'd1 : 32'd0);
    end
    check("ring8 after period", {24'd0, count8}, 32'h01);
    cycle(1, 0, 0, 0, 1, 3'd0, 8'b0001_1000);
    check("ring8 illegal load", {24'd0, count8}, 32'h01);
    check("ring8 illegal err", {31'd0, err8}, 32'd1);
    cycle(1, 0, 0, 0, 1, 3'd0, 8'b1000_0000);
    check("ring8 legal load", {24'd0, count8}, 32'h80);
    cycle(1, 1, 0, 0, 0, 3'd0, 8'd0);
    for (int d = 0; d < 2; d++) begin
      for (int i = 1; i <= 16; i++) begin
        cycle(1, 1, d[0], 1, 0, 3'd0, 8'd0);
        check($sformatf("john8 dir%0d wrap step%0d", d, i), {31'd0, wrap8},
              (i == 16) ? 32'd1 : 32'd0);
      end
      check($sformatf("john8 dir%0d after period", d), {24'd0, count8}, 32'h00);
    end
    cycle(1, 1, 0, 0, 1, 3'd0, 8'b1111_0000);
    check("john8 legal load", {24'd0, count8}, 32'hF0);

    // Random traffic; half of the loads pick a legal value for the wider instance.
    cur_mode = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) == 0) cur_mode = ~cur_mode;
      lv = $urandom_range(0, 1) ? val_of(cur_mode, int'($urandom_range(0, period(cur_mode, 8) - 1)), 8)
                                : {24'd0, 8'($urandom)};
      cycle($urandom_range(0, 19) != 0, cur_mode, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            3'($urandom), lv[7:0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iiitb_param_rc.md
IIITB_PARAM_RC -- requirements
Module: iiitb_param_rc

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-low.
REQ-002 Parameter WIDTH, default 3, sets the counter width in bits; legal values are 2 to 32.
REQ-003 Port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port Reset_n, input, 1 bit: synchronous active-low reset.
REQ-005 Port Enable, input, 1 bit: when high, advance one step per clock.
REQ-006 Port Mode, input, 1 bit: 0 selects ring (one-hot) mode; 1 selects Johnson (twisted-ring) mode.
REQ-007 Port Dir, input, 1 bit: 0 shifts toward the MSB (left); 1 shifts toward the LSB (right).
REQ-008 Port Load, input, 1 bit: synchronous parallel-load request.
REQ-009 Port Load_val, input, WIDTH bits: the value to load.
REQ-010 Port Count_out, output, WIDTH bits: the registered counter state.
REQ-011 Port Wrap, output, 1 bit: registered one-cycle pulse marking return to the seed state.
REQ-012 Port Err, output, 1 bit: registered one-cycle pulse marking that an illegal load value was replaced by the seed.

Function
REQ-013 The seed value SHALL be {0…0,1} in ring mode and all-zeros in Johnson mode.
REQ-014 The ring-left step SHALL be {q[W-2:0],q[W-1]}, and the ring-right step SHALL be {q[0],q[W-1:1]}.
REQ-015 The Johnson-left step SHALL be {q[W-2:0],~q[W-1]}, and the Johnson-right step SHALL be {~q[0],q[W-1:1]}.
REQ-016 The sequence period SHALL be WIDTH steps in ring mode and 2*WIDTH steps in Johnson mode.
REQ-017 Update priority SHALL be: Reset_n low, then a Mode change, then Load, then Enable, then hold.
REQ-018 The block SHALL register Mode internally; a clock edge where Mode differs from the registered copy SHALL load the new mode's seed and SHALL NOT step or load that cycle.
REQ-019 A ring value SHALL be legal only if exactly one bit is set.
REQ-020 A Johnson value SHALL be legal only if at most one adjacent pair q[i]/q[i+1] differs (i = 0…W-2).
REQ-021 On Load, a legal Load_val SHALL appear on Count_out the next cycle.
REQ-022 On Load, an illegal Load_val SHALL cause the seed to be loaded instead and Err to be 1 for exactly that cycle.
REQ-023 Wrap SHALL be 1 in the cycle where Count_out becomes the seed as the result of an Enable step, in either direction.
REQ-024 Wrap SHALL be 0 when the seed is reached through reset, a Mode change or Load.
REQ-025 When Enable is low and there is no Load or Mode change, Count_out SHALL hold, and Wrap and Err SHALL be 0.
REQ-026 Dir MAY change on any cycle; the step SHALL use Dir as sampled on that edge, so no state is skipped.
REQ-027 Load together with Enable SHALL load only, with no additional step.

Reset
REQ-028 While Reset_n is sampled low, Count_out SHALL take the seed of the current Mode input on the next edge.
REQ-029 During reset, Wrap and Err SHALL be 0 and the registered Mode SHALL take the Mode input.
REQ-030 Reset asserted mid-sequence SHALL take effect at the next edge and SHALL override Load, Enable and a Mode change.
REQ-031 After Reset_n rises, the first Enable step SHALL go from the seed to its successor.

Structure
REQ-032 A shared package iiitb_rc_pkg SHALL hold the mode constants MODE_RING=0 and MODE_JOHNSON=1, the direction constants DIR_LEFT=0 and DIR_RIGHT=1, and the seed functions.
REQ-033 Legality checking SHALL be one combinational sub-module, iiitb_rc_legal_chk, with inputs mode and value and output legal, parametrised by WIDTH.
REQ-034 The top level SHALL contain only the state register, the next-state multiplexer and the Wrap/Err flag registers.

Verification
REQ-035 WIDTH=3, Mode=0, Dir=0, reset then Enable=1: Count_out SHALL be 001, 010, 100, 001, with Wrap=1 on the second 001 only.
REQ-036 WIDTH=3, Mode=1, Dir=0: Count_out SHALL be 000, 001, 011, 111, 110, 100, 000, with Wrap=1 on the return to 000; with Dir=1, it SHALL run 000, 100, 110, 111, 011, 001, 000.
REQ-037 Mode=0, Load with Load_val=011: next cycle Count_out SHALL be 001 and Err=1; Load with Load_val=100: Count_out SHALL be 100, Err=0 and Wrap=0.
REQ-038 Mode=1, Load with Load_val=101: Count_out SHALL be 000 and Err=1; Load with Load_val=110: Count_out SHALL be 110.
REQ-039 Ring running at 010, toggle Mode to 1 with Enable=1: next cycle Count_out SHALL be 000 with no step and Wrap=0; the following cycle SHALL be 001.
REQ-040 Reset_n pulsed low for one cycle at Count_out=100 with Load=1: Count_out SHALL be 001 the next cycle, and Err and Wrap SHALL be 0.
REQ-041 Repeat REQ-035 to REQ-037 with WIDTH=8, checking period 8 in ring mode and period 16 in Johnson mode.
